fft_frame_capture: RTL and testbench
====================================

Name: fft_frame_capture

Overview:
Sink-side counterpart of the stimulus ROM feeder: captures FFT output frames (data_out qualified by sync_o) into an internal buffer. The frame is aligned so that bin 0 is at address 0. Host or ILA logic reads the frame back through a 1-cycle-latency read port. Sits directly after FFT_1024_top in the same clock domain.

Parameters:
- FRAME_LEN, 1024, samples per frame; power of two.
- AW, 10, address width; equals log2(FRAME_LEN).
- DW, 32, sample width; packed as {re[15:0], im[15:0]}, two's complement.
- CONTINUOUS, 0, when 1 the block re-arms automatically after each completed frame.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, synchronous, active-high reset.
- arm, input, 1, one-cycle pulse that requests capture of the next frame.
- sync_i, input, 1, FFT sync_o; high on the bin-0 sample.
- valid_i, input, 1, sample qualifier; tie high for FFT_1024_top.
- data_i, input, DW, FFT data_out.
- rd_en, input, 1, read strobe.
- rd_addr, input, AW, read address (bin index).
- rd_data, output, DW, read data; valid 1 cycle after rd_en.
- busy, output, 1, high while in ARMED or CAPTURE.
- done, output, 1, level signal: a complete frame is held in the buffer.
- frame_cnt, output, 16, number of completed frames; wraps at 16 bits.
- resync_err, output, 1, sticky flag: a sync arrived before the frame was complete.

Behaviour:
- Reset (rst=1 at a clk edge) sets the following:
  - state=IDLE, wr_addr=0;
  - busy=0, done=0, frame_cnt=0, resync_err=0, rd_data=0.
- Reset mid-capture abandons the frame. Buffer contents are not cleared.
- Only samples with valid_i=1 are processed. sync_i is ignored when valid_i=0.
- FSM states: IDLE, ARMED, CAPTURE, DONE.
  - IDLE: an arm pulse moves to ARMED and clears done.
  - ARMED: waits for valid_i & sync_i. On that cycle:
    - write data_i to address 0;
    - set wr_addr=1;
    - go to CAPTURE.
  - CAPTURE: each valid_i cycle writes data_i at wr_addr, then increments wr_addr.
    - If valid_i & sync_i arrives with wr_addr != 0:
      - set resync_err=1;
      - write this sample to address 0;
      - set wr_addr=1;
      - stay in CAPTURE (restart the frame).
    - When the write at address FRAME_LEN-1 occurs:
      - wr_addr wraps to 0;
      - go to DONE;
      - done=1 on the next cycle;
      - frame_cnt increments by 1 on the same cycle done rises.
  - DONE: done stays high. The buffer is frozen; no writes occur.
    - An arm pulse goes to ARMED and clears done.
    - If CONTINUOUS=1, the block moves to ARMED automatically on the cycle after entry, and done pulses for 1 cycle.
- arm pulses during ARMED or CAPTURE are ignored.
- Simultaneous arm and final write: the final write wins. DONE is entered and the arm is ignored.
- busy=1 exactly in ARMED and CAPTURE.
- Read port:
  - rd_data <= mem[rd_addr] on the edge where rd_en=1; otherwise rd_data holds its value.
  - Reads are legal in any state.
  - Reading an address on the same cycle it is being written returns the old data (read-first).
- frame_cnt wraps 0xFFFF to 0x0000.

Optional Feature:
- Macro FFT_CAP_PEAK_EN.
- When defined, two extra outputs are added: peak_mag (17 bits) and peak_bin (AW bits).
- Per captured sample, mag = |re| + |im|, computed as unsigned 17-bit. |-32768| = 32768, no saturation.
- The peak tracker registers mag with 1 cycle of pipeline. It updates when mag > the running max (strict, so ties keep the lowest bin).
- Running max and bin reset to 0 on the bin-0 write, including a resync.
- Values are final and stable when done rises.
- Without the macro, the ports and logic are absent.

Decomposition:
- Shared package fft_pkg:
  - FFT_N=1024, FFT_AW=10, FFT_DW=32;
  - the cap_state_t enum {IDLE, ARMED, CAPTURE, DONE};
  - re/im field slice constants.
- One natural sub-module: fft_cap_ram.
  - Simple dual-port, 1 write port / 1 registered read port, read-first.
  - Maps to block RAM.

Test Plan:
- Reset and idle: rst high 3 cycles, then feed sync_i pulses with no arm -> busy=0, done=0, frame_cnt=0, no memory writes.
- Single frame:
  - Stimulus: arm; 5 idle cycles; sync_i with data_i = k<<16 | (1023-k) for k=0..1023, valid_i=1.
  - Required: done rises exactly 1 cycle after k=1023, frame_cnt=1.
  - Readback of all 1024 addresses matches, with 1-cycle latency.
- valid gaps: same frame with valid_i deasserted every 3rd cycle -> identical buffer contents; done is delayed by the gap count.
- Resync:
  - Stimulus: arm; sync at k=0; second sync after 500 samples, then 1024 more samples with value 0xA5A5_0000+k.
  - Required: resync_err=1; buffer holds the second frame; frame_cnt=1.
- CONTINUOUS=1: three back-to-back frames -> three 1-cycle done pulses, frame_cnt=3, busy never low between frames.
- FFT_CAP_PEAK_EN:
  - Stimulus: bin 300 = {16'h8000, 16'h0001}, bin 700 equal in magnitude, all others small.
  - Required: peak_mag=32769, peak_bin=300.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, state type and sample helpers for the FFT frame-capture block.
package fft_pkg;

    localparam int unsigned FFT_N  = 1024;
    localparam int unsigned FFT_AW = 10;
    localparam int unsigned FFT_DW = 32;

    // Sample packing: {re[15:0], im[15:0]}, both two's complement.
    localparam int unsigned RE_MSB = 31;
    localparam int unsigned RE_LSB = 16;
    localparam int unsigned IM_MSB = 15;
    localparam int unsigned IM_LSB = 0;

    localparam int unsigned MAG_W  = 17;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } cap_state_t;

    // |re| + |im| without saturation; |-32768| is 32768, so 17 bits are needed.
    function automatic logic [MAG_W-1:0] cplx_mag(input logic [FFT_DW-1:0] s);
        logic [15:0] re;
        logic [15:0] im;
        logic [15:0] abs_re;
        logic [15:0] abs_im;
        re     = s[RE_MSB:RE_LSB];
        im     = s[IM_MSB:IM_LSB];
        abs_re = re[15] ? (~re + 16'd1) : re;
        abs_im = im[15] ? (~im + 16'd1) : im;
        return {1'b0, abs_re} + {1'b0, abs_im};
    endfunction

endpackage

// File: rtl/fft_cap_ram.sv
// Simple dual-port frame buffer: one write port, one registered read-first read port.
module fft_cap_ram
    import fft_pkg::*;
#(
    parameter int unsigned AW = FFT_AW,
    parameter int unsigned DW = FFT_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read sees the array before this edge's write lands, giving read-first behaviour.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem[raddr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_frame_capture.sv
// Captures one bin-0-aligned FFT output frame into a buffer readable through a 1-cycle port.
// Defining FFT_CAP_PEAK_EN adds a |re|+|im| peak tracker (peak_mag / peak_bin outputs).
module fft_frame_capture
    import fft_pkg::*;
#(
    parameter int unsigned FRAME_LEN  = FFT_N,
    parameter int unsigned AW         = FFT_AW,
    parameter int unsigned DW         = FFT_DW,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          sync_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic [15:0]   frame_cnt,
    output logic          resync_err
`ifdef FFT_CAP_PEAK_EN
    ,
    output logic [16:0]   peak_mag,
    output logic [AW-1:0] peak_bin
`endif
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

    cap_state_t    state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          resync_err_q, resync_err_d;

    logic          we;
    logic [AW-1:0] waddr;

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        done_d       = done_q;
        frame_cnt_d  = frame_cnt_q;
        resync_err_d = resync_err_q;
        we           = 1'b0;
        waddr        = wr_addr_q;

        // In continuous mode done is only a one-cycle completion pulse.
        if (CONTINUOUS) begin
            done_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                    done_d  = 1'b0;
                end
            end
            ARMED: begin
                if (valid_i && sync_i) begin
                    we        = 1'b1;
                    waddr     = '0;
                    wr_addr_d = AW'(1);
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                if (valid_i) begin
                    we = 1'b1;
                    if (sync_i && (wr_addr_q != '0)) begin
                        resync_err_d = 1'b1;
                        waddr        = '0;
                        wr_addr_d    = AW'(1);
                    end else if (wr_addr_q == LAST_ADDR) begin
                        wr_addr_d   = '0;
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        // Continuous mode re-arms straight away so a back-to-back bin 0
                        // on the very next sample is not lost.
                        state_d     = CONTINUOUS ? ARMED : DONE;
                    end else begin
                        wr_addr_d = wr_addr_q + AW'(1);
                    end
                end
            end
            DONE: begin
                if (arm || CONTINUOUS) begin
                    state_d = ARMED;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ARMED) || (state_d == CAPTURE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            frame_cnt_q  <= '0;
            resync_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            frame_cnt_q  <= frame_cnt_d;
            resync_err_q <= resync_err_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign frame_cnt  = frame_cnt_q;
    assign resync_err = resync_err_q;

    fft_cap_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (data_i),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

`ifdef FFT_CAP_PEAK_EN
    logic [MAG_W-1:0] mag;
    logic [MAG_W-1:0] peak_mag_q, peak_mag_d;
    logic [AW-1:0]    peak_bin_q, peak_bin_d;

    // Updated on the write edge itself so the result is final when done rises.
    always_comb begin
        mag        = cplx_mag(data_i);
        peak_mag_d = peak_mag_q;
        peak_bin_d = peak_bin_q;
        if (we) begin
            if (waddr == '0) begin
                peak_mag_d = mag;
                peak_bin_d = '0;
            end else if (mag > peak_mag_q) begin
                peak_mag_d = mag;
                peak_bin_d = waddr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_mag_q <= '0;
            peak_bin_q <= '0;
        end else begin
            peak_mag_q <= peak_mag_d;
            peak_bin_q <= peak_bin_d;
        end
    end

    assign peak_mag = peak_mag_q;
    assign peak_bin = peak_bin_q;
`endif

endmodule

// File: tb/tb_fft_frame_capture.sv
// Randomised self-checking bench for fft_frame_capture with a behavioural frame model.
// Peak checks are compiled in when FFT_CAP_PEAK_EN is defined.
`timescale 1ns/1ps
module tb_fft_frame_capture;

    localparam int N   = 1024;
    localparam int AW  = 10;
    localparam int CN  = 16;
    localparam int CAW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          arm = 1'b0, sync_i = 1'b0, valid_i = 1'b0, rd_en = 1'b0;
    logic [31:0]   data_i = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [31:0]   rd_data;
    logic          busy, done, resync_err;
    logic [15:0]   frame_cnt;

    logic           c_arm = 1'b0, c_sync = 1'b0, c_valid = 1'b0, c_rd_en = 1'b0;
    logic [31:0]    c_data = '0;
    logic [CAW-1:0] c_rd_addr = '0;
    logic [31:0]    c_rd_data;
    logic           c_busy, c_done, c_resync_err;
    logic [15:0]    c_frame_cnt;

`ifdef FFT_CAP_PEAK_EN
    logic [16:0]    peak_mag, c_peak_mag;
    logic [AW-1:0]  peak_bin;
    logic [CAW-1:0] c_peak_bin;
`endif

    fft_frame_capture #(
        .FRAME_LEN (N), .AW (AW), .DW (32), .CONTINUOUS (1'b0)
    ) u_dut (
        .clk (clk), .rst (rst), .arm (arm), .sync_i (sync_i), .valid_i (valid_i),
        .data_i (data_i), .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data),
        .busy (busy), .done (done), .frame_cnt (frame_cnt), .resync_err (resync_err)
`ifdef FFT_CAP_PEAK_EN
        , .peak_mag (peak_mag), .peak_bin (peak_bin)
`endif
    );

    fft_frame_capture #(
        .FRAME_LEN (CN), .AW (CAW), .DW (32), .CONTINUOUS (1'b1)
    ) u_cont (
        .clk (clk), .rst (rst), .arm (c_arm), .sync_i (c_sync), .valid_i (c_valid),
        .data_i (c_data), .rd_en (c_rd_en), .rd_addr (c_rd_addr), .rd_data (c_rd_data),
        .busy (c_busy), .done (c_done), .frame_cnt (c_frame_cnt), .resync_err (c_resync_err)
`ifdef FFT_CAP_PEAK_EN
        , .peak_mag (c_peak_mag), .peak_bin (c_peak_bin)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit rand_rd = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mag_of(input logic [31:0] w);
        int re, im;
        re = int'($signed(w[31:16]));
        im = int'($signed(w[15:0]));
        if (re < 0) re = -re;
        if (im < 0) im = -im;
        return re + im;
    endfunction

    function automatic logic [31:0] word(input int kind, input int k);
        logic [15:0] re, im;
        case (kind)
            0: return {k[15:0], 16'(1023 - k)};
            2: begin
                if (k == 300) return 32'h8000_0001;
                if (k == 700) return 32'h0001_8000;
                re = 16'($urandom_range(0, 200) - 100);
                im = 16'($urandom_range(0, 200) - 100);
                return {re, im};
            end
            3: return 32'hA5A5_0000 + 32'(k);
            default: return $urandom;
        endcase
    endfunction

    // Behavioural model of the main instance: what the buffer and flags must hold.
    logic [31:0] m_mem [N];
    bit          m_known [N];
    bit          m_live = 0, m_wait = 0, m_fill = 0, m_done = 0, m_resync = 0;
    int          m_idx = 0;
    logic [15:0] m_cnt = '0;
    logic [31:0] m_rd = '0;
    bit          m_rd_known = 0;
    logic [16:0] m_pmag = '0;
    int          m_pbin = 0;

    task automatic frame_peak();
        int best, bin, m;
        best = mag_of(m_mem[0]);
        bin  = 0;
        for (int i = 1; i < N; i++) begin
            m = mag_of(m_mem[i]);
            if (m > best) begin
                best = m;
                bin  = i;
            end
        end
        m_pmag = 17'(best);
        m_pbin = bin;
    endtask

    task automatic model_step();
        if (rst) begin
            m_live = 1; m_wait = 0; m_fill = 0; m_done = 0; m_resync = 0;
            m_idx = 0; m_cnt = '0; m_rd = '0; m_rd_known = 1;
            return;
        end
        if (!m_live) return;
        if (rd_en) begin
            m_rd       = m_mem[rd_addr];
            m_rd_known = m_known[rd_addr];
        end
        if (m_fill && valid_i) begin
            if (sync_i && m_idx != 0) begin
                m_resync = 1;
                m_idx    = 0;
            end
            m_mem[m_idx]   = data_i;
            m_known[m_idx] = 1;
            m_idx++;
            if (m_idx == N) begin
                m_fill = 0; m_done = 1; m_cnt++; m_idx = 0;
                frame_peak();
            end
        end else if (m_wait && valid_i && sync_i) begin
            m_mem[0] = data_i; m_known[0] = 1;
            m_idx = 1; m_wait = 0; m_fill = 1;
        end else if (!m_wait && !m_fill && arm) begin
            m_wait = 1;
            m_done = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of the main instance against the model.
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("busy", busy, m_wait || m_fill);
            chk("done", done, m_done);
            chk("frame_cnt", frame_cnt, m_cnt);
            chk("resync_err", resync_err, m_resync);
            if (m_rd_known) chk("rd_data", rd_data, m_rd);
`ifdef FFT_CAP_PEAK_EN
            if (m_done) begin
                chk("peak_mag", peak_mag, m_pmag);
                chk("peak_bin", peak_bin, m_pbin);
            end
`endif
        end
    end

    task automatic tick();
        if (rand_rd) begin
            rd_en   = ($urandom_range(0, 3) != 0);
            rd_addr = AW'($urandom_range(0, N - 1));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i = 0; sync_i = 0; arm = 0; data_i = '0;
    endtask

    task automatic pulse_arm();
        arm = 1; tick(); arm = 0;
    endtask

    task automatic feed_frame(input int kind, input int gap, input bit arm_last, input int nsamp);
        int k, cyc;
        k = 0; cyc = 0;
        while (k < nsamp) begin
            cyc++;
            if (gap != 0 && (cyc % gap) == 0) begin
                valid_i = 0; sync_i = 1'($urandom_range(0, 1)); data_i = $urandom; arm = 0;
                tick();
            end else begin
                valid_i = 1; sync_i = (k == 0); data_i = word(kind, k);
                arm = arm_last && (k == nsamp - 1);
                tick();
                k++;
            end
        end
        idle_inputs();
    endtask

    task automatic readback(input int kind);
        logic [31:0] exp;
        rand_rd = 0;
        for (int a = 0; a < N; a++) begin
            rd_en = 1; rd_addr = AW'(a);
            exp = word(kind, a);
            tick();
            chk("readback", rd_data, exp);
        end
        rd_en = 0;
    endtask

    task automatic noise(input int n);
        for (int i = 0; i < n; i++) begin
            valid_i = 1'($urandom_range(0, 1)); sync_i = 1'($urandom_range(0, 1));
            data_i = $urandom;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [31:0] last [CN];
    int hi, rises, lows;
    bit prev;

    initial begin
        // Reset and idle: sync pulses without arm must not start a capture.
        rst = 1;
        repeat (3) tick();
        rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_resync", resync_err, 0);
        chk("rst_rd_data", rd_data, 0);
        noise(12);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);

        // Single frame with a ramp pattern.
        pulse_arm();
        repeat (5) tick();
        feed_frame(0, 0, 0, N);
        chk("done_after_last", done, 1);
        chk("frame_cnt_1", frame_cnt, 1);
        readback(0);
        rand_rd = 1;
        noise(20);
        chk("done_frozen", done, 1);
        chk("frame_cnt_frozen", frame_cnt, 1);

        // Valid gaps every third cycle, arm coinciding with the final write.
        pulse_arm();
        feed_frame(0, 3, 1, N);
        chk("gap_done", done, 1);
        chk("gap_frame_cnt", frame_cnt, 2);
        repeat (3) tick();
        chk("arm_ignored_busy", busy, 0);
        readback(0);

        // Resync after 500 samples.
        pulse_arm();
        feed_frame(1, 0, 0, 500);
        feed_frame(3, 0, 0, N);
        chk("resync_flag", resync_err, 1);
        chk("resync_frame_cnt", frame_cnt, 3);
        readback(3);

        // Random frames with random gaps and reads throughout.
        rand_rd = 1;
        for (int f = 0; f < 2; f++) begin
            pulse_arm();
            repeat ($urandom_range(0, 4)) tick();
            feed_frame(1, $urandom_range(2, 5), 0, N);
            noise(8);
        end

        // Reset mid-capture abandons the frame.
        pulse_arm();
        feed_frame(1, 0, 0, 100);
        rst = 1; tick(); rst = 0;
        chk("midrst_busy", busy, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        chk("midrst_rd_data", rd_data, 0);
        noise(10);

        // Peak frame: two equal-magnitude bins, the lower index must win.
        pulse_arm();
        feed_frame(2, 0, 0, N);
        chk("peak_frame_cnt", frame_cnt, 1);
`ifdef FFT_CAP_PEAK_EN
        chk("peak_mag_lit", peak_mag, 32769);
        chk("peak_bin_lit", peak_bin, 300);
`endif
        rand_rd = 0; rd_en = 0;

        // Continuous instance: three back-to-back frames.
        hi = 0; rises = 0; lows = 0; prev = 0;
        c_arm = 1; tick(); c_arm = 0;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < CN; k++) begin
                c_valid = 1; c_sync = (k == 0); c_data = $urandom; last[k] = c_data;
                tick();
                if (c_done) hi++;
                if (c_done && !prev) rises++;
                if (!c_busy) lows++;
                prev = c_done;
            end
        end
        c_valid = 0; c_sync = 0;
        repeat (2) begin
            tick();
            if (c_done) hi++;
            if (c_done && !prev) rises++;
            prev = c_done;
        end
        chk("cont_done_cycles", hi, 3);
        chk("cont_done_pulses", rises, 3);
        chk("cont_busy_lows", lows, 0);
        chk("cont_frame_cnt", c_frame_cnt, 3);
        chk("cont_resync", c_resync_err, 0);
`ifdef FFT_CAP_PEAK_EN
        begin
            int best, bin;
            best = mag_of(last[0]); bin = 0;
            for (int i = 1; i < CN; i++) begin
                if (mag_of(last[i]) > best) begin
                    best = mag_of(last[i]); bin = i;
                end
            end
            chk("cont_peak_mag", c_peak_mag, best);
            chk("cont_peak_bin", c_peak_bin, bin);
        end
`endif
        for (int a = 0; a < CN; a++) begin
            c_rd_en = 1; c_rd_addr = CAW'(a);
            tick();
            chk("cont_readback", c_rd_data, last[a]);
        end
        c_rd_en = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
